// File: rtl/sentry_smac_req_gen.sv
// SMAC request generator: pops committed accesses, maps each data address to its
// stored-MAC line address, tags it with lane/sequence and pushes it under credit control.
module sentry_smac_req_gen #(
    parameter logic [31:0] SMAC_BASE       = 32'h8000_0000,
    parameter int          GRAN_SHIFT      = 6,
    parameter int          MAC_SHIFT       = 4,
    parameter int          MAX_OUTSTANDING = 16,
    parameter int          LANE_W          = 2,
    localparam int         SENTRY_WIDTH    = 2**LANE_W,
    localparam int         REQ_W           = 32 + SENTRY_WIDTH + 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       acc_fifo_addr,
    input  logic [LANE_W-1:0] acc_fifo_lane,
    input  logic              acc_fifo_empty,
    output logic              acc_fifo_rd_en,
    output logic [REQ_W-1:0]  smac_req_fifo_input,
    output logic              smac_req_fifo_wr_en,
    input  logic              smac_req_fifo_full,
    input  logic              credit_return,
    output logic [7:0]        outstanding,
    output logic              busy,
    output logic              err_underflow
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_t;

    // Packed as {addr, tag}, tag = {rotate, seq}.
    typedef struct packed {
        logic [31:0]             addr;
        logic [SENTRY_WIDTH-1:0] rotate;
        logic [7:0]              seq;
    } mem_req_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [31:0]             r_addr;
    logic [LANE_W-1:0]       r_lane;
    logic [7:0]              r_seq;
    logic [7:0]              r_outstanding;
    logic                    r_err;
    mem_req_t                r_req;
    mem_req_t                w_req_calc;
    logic [31:0]             w_smac_addr;
    logic [SENTRY_WIDTH-1:0] w_rotate;
    logic [7:0]              w_out_eff;
    logic                    w_can_issue;

    assign w_smac_addr = SMAC_BASE + ((r_addr >> GRAN_SHIFT) << MAC_SHIFT);
    assign w_rotate    = {{(SENTRY_WIDTH-1){1'b0}}, 1'b1} << r_lane;
    assign w_req_calc  = '{addr: w_smac_addr, rotate: w_rotate, seq: r_seq};

    // A credit arriving this cycle frees a slot for a push in the same cycle.
    assign w_out_eff   = (credit_return && (r_outstanding != 8'd0)) ? r_outstanding - 8'd1
                                                                      : r_outstanding;
    assign w_can_issue = !smac_req_fifo_full && (w_out_eff < 8'(MAX_OUTSTANDING));

    always_comb begin
        w_state_next        = r_state;
        acc_fifo_rd_en      = 1'b0;
        smac_req_fifo_wr_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!acc_fifo_empty && rstn) begin
                    acc_fifo_rd_en = 1'b1;
                    w_state_next   = S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_can_issue && rstn) begin
                    smac_req_fifo_wr_en = 1'b1;
                    w_state_next        = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_lane        <= '0;
            r_seq         <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_req         <= '0;
        end else begin
            r_state <= w_state_next;
            if (acc_fifo_rd_en) begin
                r_addr <= acc_fifo_addr;
                r_lane <= acc_fifo_lane;
            end
            if (r_state == S_CALC) begin
                r_req <= w_req_calc;
            end
            if (smac_req_fifo_wr_en) begin
                r_seq <= r_seq + 8'd1;
            end
            case ({smac_req_fifo_wr_en, credit_return})
                2'b10: r_outstanding <= r_outstanding + 8'd1;
                2'b01: begin
                    if (r_outstanding == 8'd0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_outstanding <= r_outstanding - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign smac_req_fifo_input = r_req;
    assign outstanding         = r_outstanding;
    assign busy                = (r_state != S_IDLE);
    assign err_underflow       = r_err;

endmodule

// File: tb/tb_sentry_smac_req_gen.sv
// Directed bench for sentry_smac_req_gen: FWFT access-FIFO model, push monitor,
// vector table for address mapping plus sequences for credit, backpressure, wrap and reset.
module tb_sentry_smac_req_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] acc_fifo_addr = '0;
    logic [1:0]  acc_fifo_lane = '0;
    logic        acc_fifo_empty = 1'b1;
    logic        acc_fifo_rd_en;
    logic [43:0] smac_req_fifo_input;
    logic        smac_req_fifo_wr_en;
    logic        smac_req_fifo_full = 1'b0;
    logic        credit_return = 1'b0;
    logic [7:0]  outstanding;
    logic        busy;
    logic        err_underflow;

    logic [31:0] b_addr = '0;
    logic [1:0]  b_lane = '0;
    logic        b_empty = 1'b1;
    logic        b_rd_en;
    logic [43:0] b_input;
    logic        b_wr_en;
    logic [7:0]  b_outstanding;
    logic        b_busy;
    logic        b_err;

    always #5 clk = ~clk;

    sentry_smac_req_gen dut (
        .clk                 (clk),
        .rstn                (rstn),
        .acc_fifo_addr       (acc_fifo_addr),
        .acc_fifo_lane       (acc_fifo_lane),
        .acc_fifo_empty      (acc_fifo_empty),
        .acc_fifo_rd_en      (acc_fifo_rd_en),
        .smac_req_fifo_input (smac_req_fifo_input),
        .smac_req_fifo_wr_en (smac_req_fifo_wr_en),
        .smac_req_fifo_full  (smac_req_fifo_full),
        .credit_return       (credit_return),
        .outstanding         (outstanding),
        .busy                (busy),
        .err_underflow       (err_underflow)
    );

    sentry_smac_req_gen #(.SMAC_BASE(32'hF000_0000), .MAX_OUTSTANDING(2)) dut_b (
        .clk                 (clk),
        .rstn                (rstn),
        .acc_fifo_addr       (b_addr),
        .acc_fifo_lane       (b_lane),
        .acc_fifo_empty      (b_empty),
        .acc_fifo_rd_en      (b_rd_en),
        .smac_req_fifo_input (b_input),
        .smac_req_fifo_wr_en (b_wr_en),
        .smac_req_fifo_full  (1'b0),
        .credit_return       (1'b0),
        .outstanding         (b_outstanding),
        .busy                (b_busy),
        .err_underflow       (b_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  lane;
    } acc_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  lane;
        logic [31:0] exp_addr;
        logic [3:0]  exp_rot;
    } vec_t;

    acc_t        accq[$];
    logic [43:0] pushes[$];
    int          push_cyc[$];
    logic [43:0] b_pushes[$];
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          auto_credit = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic refresh();
        acc_fifo_empty = (accq.size() == 0);
        if (accq.size() != 0) begin
            acc_fifo_addr = accq[0].addr;
            acc_fifo_lane = accq[0].lane;
        end
    endtask

    task automatic enqueue(input logic [31:0] a, input logic [1:0] l);
        acc_t e;
        e.addr = a;
        e.lane = l;
        accq.push_back(e);
        refresh();
    endtask

    // One clock: sample at the falling edge, apply FIFO pops just after the rising edge.
    task automatic tick();
        bit pop_a;
        bit pop_b;
        @(negedge clk);
        cyc++;
        if (auto_credit && smac_req_fifo_wr_en) credit_return = 1'b1;
        if (smac_req_fifo_wr_en) begin
            pushes.push_back(smac_req_fifo_input);
            push_cyc.push_back(cyc);
        end
        pop_a = acc_fifo_rd_en;
        if (pop_a) last_pop_cyc = cyc;
        if (b_wr_en) b_pushes.push_back(b_input);
        pop_b = b_rd_en;
        @(posedge clk);
        #1;
        if (pop_a && accq.size() != 0) accq.delete(0);
        if (pop_b) b_empty = 1'b1;
        if (auto_credit) credit_return = 1'b0;
        refresh();
    endtask

    task automatic credit_tick();
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
    endtask

    task automatic wait_pushes(input int n, input int budget, input string name);
        int k = 0;
        while (pushes.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (pushes.size() < n) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout with %0d pushes, required %0d", name, pushes.size(), n);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        accq.delete();
        refresh();
        b_empty = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        pushes.delete();
        push_cyc.delete();
        b_pushes.delete();
    endtask

    vec_t vecs[6];

    initial begin
        int errs;
        int k;
        logic [43:0] exp_req;

        vecs[0] = '{32'h0000_1040, 2'd2, 32'h8000_0410, 4'b0100};
        vecs[1] = '{32'h0000_0000, 2'd0, 32'h8000_0000, 4'b0001};
        vecs[2] = '{32'h0000_003F, 2'd1, 32'h8000_0000, 4'b0010};
        vecs[3] = '{32'h0000_0040, 2'd3, 32'h8000_0010, 4'b1000};
        vecs[4] = '{32'hFFFF_FFC0, 2'd1, 32'hBFFF_FFF0, 4'b0010};
        vecs[5] = '{32'h1234_5678, 2'd0, 32'h848D_1590, 4'b0001};

        refresh();
        do_reset();

        chk("reset_rd_en", 64'(acc_fifo_rd_en), 64'd0);
        chk("reset_wr_en", 64'(smac_req_fifo_wr_en), 64'd0);
        chk("reset_input", 64'(smac_req_fifo_input), 64'd0);
        chk("reset_outstanding", 64'(outstanding), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err", 64'(err_underflow), 64'd0);

        // Address wrap on the high-base instance, then its credit limit of 2.
        b_addr = 32'hFFFF_FFC0; b_lane = 2'd3; b_empty = 1'b0;
        k = 0;
        while (b_pushes.size() < 1 && k < 10) begin tick(); k++; end
        chk("b_wrap_count", 64'(b_pushes.size()), 64'd1);
        if (b_pushes.size() >= 1) chk("b_wrap_req", 64'(b_pushes[0]), 64'({32'h2FFF_FFF0, 4'b1000, 8'd0}));
        b_addr = 32'h1000_0000; b_lane = 2'd0; b_empty = 1'b0;
        k = 0;
        while (b_pushes.size() < 2 && k < 10) begin tick(); k++; end
        chk("b_second_count", 64'(b_pushes.size()), 64'd2);
        if (b_pushes.size() >= 2) chk("b_second_req", 64'(b_pushes[1]), 64'({32'hF400_0000, 4'b0001, 8'd1}));
        b_addr = 32'h0000_0040; b_lane = 2'd1; b_empty = 1'b0;
        repeat (10) tick();
        chk("b_limit_pushes", 64'(b_pushes.size()), 64'd2);
        chk("b_limit_outstanding", 64'(b_outstanding), 64'd2);
        chk("b_limit_busy", 64'(b_busy), 64'd1);

        // Vector table: single accesses, each returned with one credit.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            enqueue(vecs[i].addr, vecs[i].lane);
            wait_pushes(i + 1, 20, "vec_push");
            if (pushes.size() > i) begin
                chk($sformatf("vec%0d_addr", i), 64'(pushes[i][43:12]), 64'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_rot", i), 64'(pushes[i][11:8]), 64'(vecs[i].exp_rot));
                chk($sformatf("vec%0d_seq", i), 64'(pushes[i][7:0]), 64'(i));
                chk($sformatf("vec%0d_latency", i), 64'(push_cyc[i] - last_pop_cyc), 64'd2);
            end
            chk($sformatf("vec%0d_outstanding", i), 64'(outstanding), 64'd1);
            credit_tick();
            chk($sformatf("vec%0d_returned", i), 64'(outstanding), 64'd0);
        end

        // Credit limit: 17 accesses, no credits.
        do_reset();
        for (int i = 0; i < 17; i++) enqueue(32'(i) << 6, 2'(i));
        repeat (80) tick();
        chk("limit_pushes", 64'(pushes.size()), 64'd16);
        chk("limit_outstanding", 64'(outstanding), 64'd16);
        chk("limit_busy", 64'(busy), 64'd1);
        errs = 0;
        for (int i = 0; i < 16 && i < pushes.size(); i++) begin
            exp_req = {32'h8000_0000 + (32'(i) << 4), 4'(1 << (i % 4)), 8'(i)};
            if (pushes[i] !== exp_req) errs++;
        end
        chk("limit_first16", 64'(errs), 64'd0);
        credit_tick();
        chk("limit_17th_push", 64'(pushes.size()), 64'd17);
        if (pushes.size() >= 17) begin
            chk("limit_17th_same_cycle", 64'(push_cyc[16]), 64'(cyc));
            chk("limit_17th_req", 64'(pushes[16]), 64'({32'h8000_0100, 4'b0001, 8'd16}));
        end
        chk("limit_outstanding_after", 64'(outstanding), 64'd16);
        repeat (16) credit_tick();
        chk("limit_drained", 64'(outstanding), 64'd0);
        chk("limit_no_err", 64'(err_underflow), 64'd0);

        // Backpressure while in S_ISSUE.
        smac_req_fifo_full = 1'b1;
        enqueue(32'h0000_2000, 2'd1);
        repeat (2) tick();
        exp_req = {32'h8000_0800, 4'b0010, 8'd17};
        chk("bp_input_enter", 64'(smac_req_fifo_input), 64'(exp_req));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp_hold%0d_input", i), 64'(smac_req_fifo_input), 64'(exp_req));
            chk($sformatf("bp_hold%0d_nopush", i), 64'(pushes.size()), 64'd17);
        end
        smac_req_fifo_full = 1'b0;
        tick();
        chk("bp_release_push", 64'(pushes.size()), 64'd18);
        if (pushes.size() >= 18) chk("bp_release_req", 64'(pushes[17]), 64'(exp_req));
        credit_tick();

        // Push and credit in the same cycle leave the count unchanged.
        enqueue(32'h0000_0080, 2'd0);
        wait_pushes(19, 20, "simul_first");
        chk("simul_before", 64'(outstanding), 64'd1);
        auto_credit = 1'b1;
        enqueue(32'h0000_00C0, 2'd0);
        wait_pushes(20, 20, "simul_second");
        auto_credit = 1'b0;
        chk("simul_after", 64'(outstanding), 64'd1);
        credit_tick();
        chk("simul_drained", 64'(outstanding), 64'd0);

        // Sequence wrap over 300 accesses with immediate credits.
        do_reset();
        auto_credit = 1'b1;
        for (int i = 0; i < 300; i++) enqueue(32'(i) << 6, 2'(i));
        wait_pushes(300, 1200, "wrap_push");
        auto_credit = 1'b0;
        if (pushes.size() >= 300) begin
            chk("wrap_seq255", 64'(pushes[255][7:0]), 64'd255);
            chk("wrap_seq256", 64'(pushes[256][7:0]), 64'd0);
            errs = 0;
            for (int i = 0; i < 300; i++) begin
                exp_req = {32'h8000_0000 + (32'(i) << 4), 4'(1 << (i % 4)), 8'(i)};
                if (pushes[i] !== exp_req) errs++;
            end
            chk("wrap_order", 64'(errs), 64'd0);
        end
        chk("wrap_outstanding", 64'(outstanding), 64'd0);
        chk("wrap_no_err", 64'(err_underflow), 64'd0);

        // Underflow is sticky.
        credit_tick();
        chk("uflow_err", 64'(err_underflow), 64'd1);
        chk("uflow_outstanding", 64'(outstanding), 64'd0);
        repeat (3) tick();
        chk("uflow_sticky", 64'(err_underflow), 64'd1);

        // Reset while in S_CALC drops the in-flight access.
        do_reset();
        chk("rst_clears_err", 64'(err_underflow), 64'd0);
        enqueue(32'h0000_0040, 2'd0);
        wait_pushes(1, 20, "midrst_first");
        enqueue(32'h0000_0080, 2'd1);
        tick();
        chk("midrst_in_calc", 64'(busy), 64'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_outstanding", 64'(outstanding), 64'd0);
        chk("midrst_input", 64'(smac_req_fifo_input), 64'd0);
        repeat (5) tick();
        chk("midrst_no_push", 64'(pushes.size()), 64'd1);
        enqueue(32'h0000_00C0, 2'd2);
        wait_pushes(2, 20, "midrst_next");
        if (pushes.size() >= 2) chk("midrst_next_req", 64'(pushes[1]), 64'({32'h8000_0030, 4'b0100, 8'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
